// File: rtl/ssd1306_spi_rx.sv
// SSD1306 4-wire SPI receiver: oversampled byte assembly, command subset decode
// and a COLS x PAGES framebuffer with a synchronous read port.
module ssd1306_spi_rx #(
  parameter int COLS        = 128,
  parameter int PAGES       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_,
  input  logic       sck,
  input  logic       sda,
  input  logic       d_c,
  input  logic       res,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       display_on,
  output logic [7:0] contrast,
  output logic [1:0] addr_mode,
  output logic [6:0] col_ptr,
  output logic [2:0] page_ptr
);

  localparam int DEPTH = COLS * PAGES;
  localparam logic [4:0] SYNC_RST = 5'b10001; // {res, d_c, sda, sck, ss_} idle levels

  typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;

  // ---------------- input synchronizers ----------------
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic sck_d;
  logic ss_s, sck_s, sda_s, dc_s, res_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
      sck_d  <= 1'b0;
    end else begin
      sync_q[0] <= {res, d_c, sda, sck, ss_};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_d <= sck_s;
    end
  end

  assign {res_s, dc_s, sda_s, sck_s, ss_s} = sync_q[SYNC_STAGES-1];

  // ---------------- byte assembly ----------------
  logic       rise, got_byte;
  logic [2:0] bit_cnt;
  logic [6:0] sr;
  logic [7:0] rx_byte;

  assign rise     = sck_s & ~sck_d & ~ss_s;
  assign got_byte = rise & (bit_cnt == 3'd7);
  assign rx_byte  = {sr, sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      sr         <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else if (!res_s) begin
      bit_cnt    <= '0;
      sr         <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= got_byte;
      if (ss_s) begin
        bit_cnt <= '0;
      end else if (rise) begin
        sr      <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data <= rx_byte;
          byte_dc   <= dc_s;
        end
      end
    end
  end

  // ---------------- command FSM and write pointers ----------------
  state_t     state, state_n;
  logic [7:0] cmd_q, cmd_n, arg_q, arg_n, contrast_n;
  logic       disp_n, fb_we;
  logic [1:0] mode_n;
  logic [6:0] col_n, col_start, col_start_n, col_end, col_end_n;
  logic [2:0] page_n, page_start, page_start_n, page_end, page_end_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      arg_q      <= '0;
      display_on <= 1'b0;
      contrast   <= 8'h7F;
      addr_mode  <= 2'b10;
      col_ptr    <= '0;
      page_ptr   <= '0;
      col_start  <= '0;
      col_end    <= 7'd127;
      page_start <= '0;
      page_end   <= 3'd7;
    end else begin
      state      <= state_n;
      cmd_q      <= cmd_n;
      arg_q      <= arg_n;
      display_on <= disp_n;
      contrast   <= contrast_n;
      addr_mode  <= mode_n;
      col_ptr    <= col_n;
      page_ptr   <= page_n;
      col_start  <= col_start_n;
      col_end    <= col_end_n;
      page_start <= page_start_n;
      page_end   <= page_end_n;
    end
  end

  always_comb begin
    state_n      = state;
    cmd_n        = cmd_q;
    arg_n        = arg_q;
    disp_n       = display_on;
    contrast_n   = contrast;
    mode_n       = addr_mode;
    col_n        = col_ptr;
    page_n       = page_ptr;
    col_start_n  = col_start;
    col_end_n    = col_end;
    page_start_n = page_start;
    page_end_n   = page_end;
    fb_we        = 1'b0;

    if (got_byte) begin
      if (dc_s) begin
        // Data always wins: any half-received command is abandoned.
        state_n = IDLE;
        fb_we   = 1'b1;
        case (addr_mode)
          2'b00: begin
            if (col_ptr == col_end) begin
              col_n  = col_start;
              page_n = (page_ptr == page_end) ? page_start : page_ptr + 3'd1;
            end else begin
              col_n = col_ptr + 7'd1;
            end
          end
          2'b01: begin
            if (page_ptr == page_end) begin
              page_n = page_start;
              col_n  = (col_ptr == col_end) ? col_start : col_ptr + 7'd1;
            end else begin
              page_n = page_ptr + 3'd1;
            end
          end
          default: col_n = (col_ptr == 7'(COLS - 1)) ? 7'd0 : col_ptr + 7'd1;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (rx_byte[7:1] == 7'h57)            disp_n     = rx_byte[0];
            else if (rx_byte[7:4] == 4'h0)        col_n[3:0] = rx_byte[3:0];
            else if (rx_byte[7:3] == 5'b00010)    col_n[6:4] = rx_byte[2:0];
            else if (rx_byte[7:3] == 5'b10110)    page_n     = rx_byte[2:0];
            else begin
              case (rx_byte)
                8'h81, 8'h20, 8'h21, 8'h22, 8'hA8, 8'hD3,
                8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: begin
                  cmd_n   = rx_byte;
                  state_n = ARG1;
                end
                default: ;
              endcase
            end
          end
          ARG1: begin
            state_n = IDLE;
            case (cmd_q)
              8'h81: contrast_n = rx_byte;
              8'h20: if (rx_byte[1:0] != 2'b11) mode_n = rx_byte[1:0];
              8'h21, 8'h22: begin
                arg_n   = rx_byte;
                state_n = ARG2;
              end
              default: ;
            endcase
          end
          ARG2: begin
            state_n = IDLE;
            if (cmd_q == 8'h21) begin
              col_start_n = arg_q[6:0];
              col_end_n   = rx_byte[6:0];
              col_n       = arg_q[6:0];
            end else begin
              page_start_n = arg_q[2:0];
              page_end_n   = rx_byte[2:0];
              page_n       = arg_q[2:0];
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end

    if (!res_s) begin
      state_n      = IDLE;
      cmd_n        = '0;
      arg_n        = '0;
      disp_n       = 1'b0;
      contrast_n   = 8'h7F;
      mode_n       = 2'b10;
      col_n        = '0;
      page_n       = '0;
      col_start_n  = '0;
      col_end_n    = 7'd127;
      page_start_n = '0;
      page_end_n   = 3'd7;
      fb_we        = 1'b0;
    end
  end

  // ---------------- framebuffer ----------------
  logic [7:0] fb [DEPTH];
  logic [9:0] wr_addr;

  assign wr_addr = 10'(page_ptr) * 10'(COLS) + 10'(col_ptr);

  // Read-before-write: a same-address read returns the old byte.
  always_ff @(posedge clk) begin
    if (fb_we) fb[wr_addr] <= rx_byte;
    rd_data <= fb[rd_addr];
  end

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Bench for ssd1306_spi_rx: SPI byte driver, behavioural panel model, scenario tasks.
module tb_ssd1306_spi_rx;

  logic       clk = 1'b0;
  logic       rst, ss_, sck, sda, d_c, res;
  logic [9:0] rd_addr;
  logic [7:0] rd_data, byte_data, contrast;
  logic       byte_valid, byte_dc, display_on;
  logic [1:0] addr_mode;
  logic [6:0] col_ptr;
  logic [2:0] page_ptr;

  ssd1306_spi_rx dut (
    .clk(clk), .rst(rst), .ss_(ss_), .sck(sck), .sda(sda), .d_c(d_c), .res(res),
    .rd_addr(rd_addr), .rd_data(rd_data), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_dc(byte_dc), .display_on(display_on),
    .contrast(contrast), .addr_mode(addr_mode), .col_ptr(col_ptr), .page_ptr(page_ptr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, bv_cnt = 0;
  always @(negedge clk) if (byte_valid) bv_cnt++;

  // ---------------- reference model ----------------
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_disp, m_con;
  int m_cmd, m_need;
  int m_args[$];
  logic [7:0] m_fb [1024];
  bit         m_wr [1024];

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_mode = 2; m_disp = 0; m_con = 8'h7F; m_need = 0; m_cmd = 0;
    m_args.delete();
  endtask

  task automatic model_apply();
    case (m_cmd)
      8'h81: m_con = m_args[0];
      8'h20: if ((m_args[0] & 3) != 3) m_mode = m_args[0] & 3;
      8'h21: begin m_cs = m_args[0] & 127; m_ce = m_args[1] & 127; m_col = m_cs; end
      8'h22: begin m_ps = m_args[0] & 7; m_pe = m_args[1] & 7; m_page = m_ps; end
      default: ;
    endcase
    m_args.delete();
  endtask

  task automatic model_byte(input int b, input bit dc);
    if (dc) begin
      m_need = 0;
      m_args.delete();
      m_fb[m_page*128 + m_col] = 8'(b);
      m_wr[m_page*128 + m_col] = 1'b1;
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          m_col = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else if (m_need > 0) begin
      m_args.push_back(b);
      m_need--;
      if (m_need == 0) model_apply();
    end else if (b == 8'hAE || b == 8'hAF) m_disp = b & 1;
    else if (b <= 8'h0F) m_col = (m_col & 8'h70) | b;
    else if (b <= 8'h17) m_col = (m_col & 8'h0F) | ((b & 7) << 4);
    else if (b >= 8'hB0 && b <= 8'hB7) m_page = b & 7;
    else if (b == 8'h21 || b == 8'h22) begin m_cmd = b; m_need = 2; end
    else if (b inside {8'h81, 8'h20, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D}) begin
      m_cmd = b; m_need = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    @(negedge clk);
    ss_ = 1'b0;
    d_c = dc;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk) sck = 1'b0; sda = b[i];
      @(negedge clk);
      @(negedge clk) sck = 1'b1;
      @(negedge clk);
    end
    @(negedge clk) sck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, 8, dc);
    model_byte(int'(b), dc);
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    @(negedge clk) rd_addr = 10'(a);
    @(negedge clk) d = rd_data;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rst_bv got %b exp 0", byte_valid); end
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL rst_bd got %h exp 00", byte_data); end
    checks++; if (byte_dc !== 1'b0) begin errors++; $display("FAIL rst_bdc got %b exp 0", byte_dc); end
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL rst_disp got %b exp 0", display_on); end
    checks++; if (contrast !== 8'h7F) begin errors++; $display("FAIL rst_con got %h exp 7f", contrast); end
    checks++; if (addr_mode !== 2'b10) begin errors++; $display("FAIL rst_mode got %b exp 10", addr_mode); end
    checks++; if (col_ptr !== 7'd0) begin errors++; $display("FAIL rst_col got %0d exp 0", col_ptr); end
    checks++; if (page_ptr !== 3'd0) begin errors++; $display("FAIL rst_page got %0d exp 0", page_ptr); end
    // panel reset pin clears state as well
    send_byte(8'hAF, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'h10, 1'b0);
    @(negedge clk) res = 1'b0;
    repeat (6) @(negedge clk);
    res = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL res_disp got %b exp 0", display_on); end
    checks++; if (contrast !== 8'h7F) begin errors++; $display("FAIL res_con got %h exp 7f", contrast); end
  endtask

  task automatic test_cmds();
    int bv0 = bv_cnt;
    send_byte(8'hAF, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'hCF, 1'b0);
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL cmd_disp got %b exp 1", display_on); end
    checks++; if (contrast !== 8'hCF) begin errors++; $display("FAIL cmd_con got %h exp cf", contrast); end
    checks++; if (bv_cnt - bv0 !== 3) begin errors++; $display("FAIL cmd_bvcnt got %0d exp 3", bv_cnt - bv0); end
    checks++; if (byte_dc !== 1'b0) begin errors++; $display("FAIL cmd_dc got %b exp 0", byte_dc); end
    checks++; if (byte_data !== 8'hCF) begin errors++; $display("FAIL cmd_bd got %h exp cf", byte_data); end
  endtask

  task automatic test_fill();
    logic [7:0] d;
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b1);
    checks++; if (addr_mode !== 2'b00) begin errors++; $display("FAIL fill_mode got %b exp 00", addr_mode); end
    checks++; if (col_ptr !== 7'd0) begin errors++; $display("FAIL fill_col got %0d exp 0", col_ptr); end
    checks++; if (page_ptr !== 3'd0) begin errors++; $display("FAIL fill_page got %0d exp 0", page_ptr); end
    for (int i = 0; i < 1024; i++) begin
      rd(i, d);
      checks++;
      if (d !== 8'(i % 256)) begin errors++; $display("FAIL fill_fb[%0d] got %h exp %h", i, d, 8'(i % 256)); end
    end
  endtask

  task automatic test_window();
    logic [7:0] d;
    logic [7:0] exp_v [4] = '{8'hA5, 8'hA2, 8'hA3, 8'hA4};
    int         adr   [4] = '{2*128+16, 2*128+17, 3*128+16, 3*128+17};
    send_byte(8'h21, 0); send_byte(8'h10, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    for (int i = 1; i <= 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd(adr[i], d);
      checks++;
      if (d !== exp_v[i]) begin errors++; $display("FAIL win_fb[%0d] got %h exp %h", adr[i], d, exp_v[i]); end
    end
    checks++; if (col_ptr !== 7'd17) begin errors++; $display("FAIL win_col got %0d exp 17", col_ptr); end
    checks++; if (page_ptr !== 3'd2) begin errors++; $display("FAIL win_page got %0d exp 2", page_ptr); end
  endtask

  task automatic test_page_mode();
    logic [7:0] d;
    apply_reset();
    send_byte(8'hB3, 0); send_byte(8'h05, 0); send_byte(8'h12, 0);
    send_byte(8'h55, 1);
    rd(3*128 + 8'h25, d);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL pg_fb got %h exp 55", d); end
    checks++; if (col_ptr !== 7'h26) begin errors++; $display("FAIL pg_col got %h exp 26", col_ptr); end
    checks++; if (page_ptr !== 3'd3) begin errors++; $display("FAIL pg_page got %0d exp 3", page_ptr); end
  endtask

  task automatic test_partial();
    int bv0 = bv_cnt;
    send_bits(8'hE7, 5, 1'b0);
    @(negedge clk) ss_ = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h3C, 1'b1);
    checks++; if (bv_cnt - bv0 !== 1) begin errors++; $display("FAIL part_bvcnt got %0d exp 1", bv_cnt - bv0); end
    checks++; if (byte_data !== 8'h3C) begin errors++; $display("FAIL part_bd got %h exp 3c", byte_data); end
    checks++; if (byte_dc !== 1'b1) begin errors++; $display("FAIL part_dc got %b exp 1", byte_dc); end
    checks++; if (col_ptr !== 7'h27) begin errors++; $display("FAIL part_col got %h exp 27", col_ptr); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int bv0;
    apply_reset();
    send_byte(8'h81, 1'b0);
    send_byte(8'h77, 1'b1);
    checks++; if (contrast !== 8'h7F) begin errors++; $display("FAIL abort_con got %h exp 7f", contrast); end
    rd(0, d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL abort_fb got %h exp 77", d); end
    send_byte(8'hAF, 1'b0);
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL abort_idle got %b exp 1", display_on); end
    checks++; if (contrast !== 8'h7F) begin errors++; $display("FAIL abort_con2 got %h exp 7f", contrast); end
    // reset in the middle of a byte
    send_bits(8'hA5, 3, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++; if (display_on !== 1'b0) begin errors++; $display("FAIL mid_disp got %b exp 0", display_on); end
    checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL mid_bd got %h exp 00", byte_data); end
    checks++; if (col_ptr !== 7'd0) begin errors++; $display("FAIL mid_col got %0d exp 0", col_ptr); end
    checks++; if (addr_mode !== 2'b10) begin errors++; $display("FAIL mid_mode got %b exp 10", addr_mode); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    bv0 = bv_cnt;
    send_byte(8'hC3, 1'b0);
    checks++; if (bv_cnt - bv0 !== 1) begin errors++; $display("FAIL mid_bvcnt got %0d exp 1", bv_cnt - bv0); end
    checks++; if (byte_data !== 8'hC3) begin errors++; $display("FAIL mid_bd2 got %h exp c3", byte_data); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] ign [5] = '{8'hA8, 8'hD9, 8'h8D, 8'hE3, 8'h40};
    for (int u = 0; u < 70; u++) begin
      int r = $urandom_range(0, 9);
      int s, e;
      case (r)
        0, 1, 2, 3: for (int k = 0; k <= $urandom_range(0, 3); k++) send_byte(8'($urandom), 1'b1);
        4: send_byte(8'hAE + 8'($urandom_range(0, 1)), 1'b0);
        5: case ($urandom_range(0, 2))
             0: send_byte(8'($urandom_range(0, 15)), 1'b0);
             1: send_byte(8'h10 + 8'($urandom_range(0, 7)), 1'b0);
             default: send_byte(8'hB0 + 8'($urandom_range(0, 7)), 1'b0);
           endcase
        6: begin send_byte(8'h81, 0); send_byte(8'($urandom), 0); end
        7: begin send_byte(8'h20, 0); send_byte(8'($urandom_range(0, 3)), 0); end
        8: begin
          bit pg = 1'($urandom_range(0, 1));
          s = pg ? $urandom_range(0, 7) : $urandom_range(0, 127);
          e = pg ? $urandom_range(s, 7) : $urandom_range(s, 127);
          send_byte(pg ? 8'h22 : 8'h21, 0);
          send_byte(8'(s) | (8'($urandom_range(0, 1)) << 7), 0);
          if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b1);
          else send_byte(8'(e), 0);
        end
        default: begin
          int k = $urandom_range(0, 4);
          send_byte(ign[k], 0);
          if (k < 3) send_byte(8'($urandom), 0);
        end
      endcase
      checks++; if (col_ptr !== 7'(m_col)) begin errors++; $display("FAIL rnd_col u%0d got %0d exp %0d", u, col_ptr, m_col); end
      checks++; if (page_ptr !== 3'(m_page)) begin errors++; $display("FAIL rnd_page u%0d got %0d exp %0d", u, page_ptr, m_page); end
      checks++; if (addr_mode !== 2'(m_mode)) begin errors++; $display("FAIL rnd_mode u%0d got %0d exp %0d", u, addr_mode, m_mode); end
      checks++; if (display_on !== 1'(m_disp)) begin errors++; $display("FAIL rnd_disp u%0d got %b exp %0d", u, display_on, m_disp); end
      checks++; if (contrast !== 8'(m_con)) begin errors++; $display("FAIL rnd_con u%0d got %h exp %h", u, contrast, 8'(m_con)); end
    end
    for (int i = 0; i < 1024; i++) begin
      if (m_wr[i]) begin
        rd(i, d);
        checks++;
        if (d !== m_fb[i]) begin errors++; $display("FAIL rnd_fb[%0d] got %h exp %h", i, d, m_fb[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; ss_ = 1'b1; sck = 1'b0; sda = 1'b0; d_c = 1'b0; res = 1'b1; rd_addr = '0;
    for (int i = 0; i < 1024; i++) m_wr[i] = 1'b0;
    model_reset();
    test_reset();
    test_cmds();
    test_fill();
    test_window();
    test_page_mode();
    test_partial();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_rx.md
# ssd1306_spi_rx

Receive-side model of an SSD1306 display on its 4-wire SPI interface. Oversamples SS_/SCK/SDA/D_C on the system clock, assembles bytes, decodes the command subset our display driver emits and writes data bytes into a 128x8-page (1024-byte) framebuffer. A synchronous read port exposes that framebuffer. Used as the far-end model in display-driver benches and as an on-FPGA mirror of the panel contents (e.g. for video or UART dump).

## Interface
Parameters:
- COLS, 128, columns per page (col_ptr is 7 bits).
- PAGES, 8, pages (page_ptr is 3 bits).
- SYNC_STAGES, 2, synchronizer flops on each SPI input.

Ports:
- clk  in  1  system clock; must be at least 4x the SCK frequency.
- rst  in  1  asynchronous, active-high reset.
- ss_  in  1  chip select, active low.
- sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), sampled on rising edge.
- sda  in  1  MOSI, MSB first.
- d_c  in  1  1 = data byte, 0 = command byte.
- res  in  1  panel reset, active low.
- rd_addr  in  10  framebuffer read address = page*128 + column.
- rd_data  out  8  framebuffer read data, 1-cycle latency.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  last received byte.
- byte_dc  out  1  d_c value captured with byte_data.
- display_on  out  1  set by 0xAF, cleared by 0xAE.
- contrast  out  8  last 0x81 argument.
- addr_mode  out  2  00 horizontal, 01 vertical, 10 page.
- col_ptr  out  7  current write column.
- page_ptr  out  3  current write page.

## Operation
- Reset values (rst, or synced res low): byte_valid 0, byte_data 0, byte_dc 0, display_on 0, contrast 8'h7F, addr_mode 2'b10, col_ptr 0, page_ptr 0, col window 0..127, page window 0..7, bit counter 0, command FSM IDLE. rd_data and framebuffer contents are not reset.
- Inputs pass through SYNC_STAGES flops. SCK rising edge = synced sck high and its delayed copy low, qualified by synced ss_ low.
- Each qualified edge shifts synced sda into an 8-bit shift register and increments a 3-bit bit counter. On the 8th edge the byte, plus synced d_c, is captured into byte_data/byte_dc and byte_valid pulses.
- Synced ss_ high clears the bit counter. A partial byte is discarded. FSM and pointer state persist across ss_ toggles.
- Command FSM states:
  - IDLE: decode command byte.
  - ARG1: await first argument.
  - ARG2: await second argument.
- Command decode:
  - 0xAE/0xAF: set display_on.
  - 0x00–0x0F: col_ptr[3:0] = cmd[3:0].
  - 0x10–0x17: col_ptr[6:4] = cmd[2:0].
  - 0xB0–0xB7: page_ptr = cmd[2:0].
  - 0x81 + 1 arg: contrast.
  - 0x20 + 1 arg: addr_mode = arg[1:0]; value 11 leaves the mode unchanged.
  - 0x21 + 2 args: col_start, col_end (arg[6:0]); col_ptr = col_start.
  - 0x22 + 2 args: page_start, page_end (arg[2:0]); page_ptr = page_start.
  - 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D: consume 1 argument and ignore it.
  - All other commands: ignored, 0 arguments.
- A data byte arriving in ARG1/ARG2 aborts the command. The FSM returns to IDLE and the byte is written normally.
- Data byte: write fb[page_ptr*128 + col_ptr], then advance the pointers:
  - Horizontal: col == col_end ? (col = col_start; page = page == page_end ? page_start : page+1) : col+1.
  - Vertical: page == page_end ? (page = page_start; col = col == col_end ? col_start : col+1) : page+1.
  - Page: col = col == 127 ? 0 : col+1; page unchanged.

## Timing
- Raw SCK high first sampled at clk edge k: shift occurs at edge k+SYNC_STAGES. On the 8th bit, byte_valid is high in the cycle after edge k+SYNC_STAGES.
- Framebuffer write, pointer update and command effects take place on the same edge that raises byte_valid. They are visible on the outputs in that same cycle.
- Read port: rd_data = fb[rd_addr] sampled at the previous edge. A simultaneous write and read to the same address returns the old data.
- rst asserted mid-byte: all state clears immediately. The next byte begins at bit 0 once ss_/sck resume.
- SCK edges while ss_ is high are ignored.

## Test plan
- Send commands AF, 81 CF -> display_on = 1, contrast = 0xCF, one byte_valid per byte with byte_dc = 0.
- Send 20 00, 21 00 7F, 22 00 07, then 1024 data bytes 0..255 repeating -> fb[i] = i mod 256. After the last byte, col_ptr = 0 and page_ptr = 0 (window wrap).
- Send 21 10 11, 22 02 03 in horizontal mode, then 5 bytes A1..A5 -> writes land at (p2,c16), (p2,c17), (p3,c16), (p3,c17), (p2,c16), so 0xA5 overwrites 0xA1.
- Default page mode, send B3 05 12 then data 0x55 -> fb[3*128+0x25] = 0x55, col_ptr = 0x26.
- Clock 5 bits, raise ss_, then send a full byte 0x3C with d_c = 1 -> exactly one byte_valid, byte_data = 0x3C.
- Send 81, then a data byte 0x77 -> contrast unchanged at 0x7F, 0x77 written at (0,0), FSM in IDLE. Assert rst mid-byte -> all outputs return to their reset values.
